// File: rtl/scr1_axi_single_master.sv
// Single-outstanding AXI4 initiator: turns a simple core-style request/response
// port into single-beat AXI reads and writes, with local rejection of
// misaligned accesses.
module scr1_axi_single_master #(
  parameter int unsigned W_ID   = 4,
  parameter int unsigned W_ADR  = 32,
  parameter int unsigned W_DATA = 32,
  parameter int unsigned TXN_ID = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Core-side request/response port
  input  logic                  req_i,
  output logic                  req_ack_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_width_i,
  input  logic [W_ADR-1:0]      req_addr_i,
  input  logic [W_DATA-1:0]     req_wdata_i,
  output logic                  resp_valid_o,
  output logic [W_DATA-1:0]     resp_rdata_o,
  output logic                  resp_err_o,
  // AXI write-address channel
  output logic                  awvalid_o,
  input  logic                  awready_i,
  output logic [W_ID-1:0]       awid_o,
  output logic [W_ADR-1:0]      awaddr_o,
  output logic [2:0]            awsize_o,
  output logic [7:0]            awlen_o,
  output logic [1:0]            awburst_o,
  // AXI write-data channel
  output logic                  wvalid_o,
  input  logic                  wready_i,
  output logic [W_DATA-1:0]     wdata_o,
  output logic [W_DATA/8-1:0]   wstrb_o,
  output logic                  wlast_o,
  // AXI write-response channel
  input  logic                  bvalid_i,
  output logic                  bready_o,
  input  logic [W_ID-1:0]       bid_i,
  input  logic [1:0]            bresp_i,
  // AXI read-address channel
  output logic                  arvalid_o,
  input  logic                  arready_i,
  output logic [W_ID-1:0]       arid_o,
  output logic [W_ADR-1:0]      araddr_o,
  output logic [2:0]            arsize_o,
  output logic [7:0]            arlen_o,
  output logic [1:0]            arburst_o,
  // AXI read-data channel
  input  logic                  rvalid_i,
  output logic                  rready_o,
  input  logic [W_ID-1:0]       rid_i,
  input  logic [W_DATA-1:0]     rdata_i,
  input  logic                  rlast_i,
  input  logic [1:0]            rresp_i
);

  localparam int unsigned     StrbW     = W_DATA / 8;
  localparam logic [W_ID-1:0] TxnId     = W_ID'(TXN_ID);
  localparam logic [1:0]      BurstIncr = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdD,
    StWrAw,
    StWrB,
    StErr
  } state_e;

  state_e             state_q;
  logic               aw_done_q, w_done_q;
  logic               awvalid_q, wvalid_q, arvalid_q, rready_q, bready_q;
  logic [W_ADR-1:0]   awaddr_q, araddr_q;
  logic [2:0]         awsize_q, arsize_q;
  logic [7:0]         awlen_q, arlen_q;
  logic [1:0]         awburst_q, arburst_q;
  logic [W_DATA-1:0]  wdata_q;
  logic [StrbW-1:0]   wstrb_q;
  logic               wlast_q;
  logic               resp_valid_q, resp_err_q;
  logic [W_DATA-1:0]  resp_rdata_q;

  logic               req_mis;
  logic [StrbW-1:0]   req_strb;
  logic               aw_done_d, w_done_d;
  logic               r_err, b_err;

  // Request decode: alignment check and lane strobes for the incoming request
  always_comb begin
    req_mis  = 1'b0;
    req_strb = '1;
    case (req_width_i)
      2'd0: begin
        req_mis  = 1'b0;
        req_strb = StrbW'(1) << req_addr_i[1:0];
      end
      2'd1: begin
        req_mis  = req_addr_i[0];
        req_strb = StrbW'(3) << req_addr_i[1:0];
      end
      2'd2: begin
        req_mis  = |req_addr_i[1:0];
        req_strb = '1;
      end
      default: begin
        req_mis  = 1'b1;
        req_strb = '1;
      end
    endcase
  end

  // Handshake completion and response error evaluation
  always_comb begin
    aw_done_d = aw_done_q | (awvalid_q & awready_i);
    w_done_d  = w_done_q | (wvalid_q & wready_i);
    r_err     = (rresp_i != 2'b00) | (rid_i != TxnId) | ~rlast_i;
    b_err     = (bresp_i != 2'b00) | (bid_i != TxnId);
  end

  // Transaction FSM with registered AXI and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      bready_q     <= 1'b0;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      awsize_q     <= '0;
      arsize_q     <= '0;
      awlen_q      <= '0;
      arlen_q      <= '0;
      awburst_q    <= '0;
      arburst_q    <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wlast_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      // Response is a single-cycle pulse
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_i) begin
            if (req_mis) begin
              state_q      <= StErr;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (req_we_i) begin
              state_q   <= StWrAw;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              awaddr_q  <= req_addr_i;
              awsize_q  <= {1'b0, req_width_i};
              awlen_q   <= 8'd0;
              awburst_q <= BurstIncr;
              wdata_q   <= req_wdata_i;
              wstrb_q   <= req_strb;
              wlast_q   <= 1'b1;
            end else begin
              state_q   <= StRdA;
              arvalid_q <= 1'b1;
              araddr_q  <= req_addr_i;
              arsize_q  <= {1'b0, req_width_i};
              arlen_q   <= 8'd0;
              arburst_q <= BurstIncr;
            end
          end
        end
        StRdA: begin
          if (arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdD;
          end
        end
        StRdD: begin
          if (rvalid_i) begin
            rready_q     <= 1'b0;
            resp_rdata_q <= rdata_i;
            resp_valid_q <= 1'b1;
            resp_err_q   <= r_err;
            state_q      <= StIdle;
          end
        end
        StWrAw: begin
          // Address and data channels complete independently
          if (awvalid_q && awready_i) awvalid_q <= 1'b0;
          if (wvalid_q && wready_i) wvalid_q <= 1'b0;
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d && w_done_d) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= StWrB;
          end
        end
        StWrB: begin
          if (bvalid_i) begin
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= b_err;
            state_q      <= StIdle;
          end
        end
        StErr: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ack_o    = (state_q == StIdle);
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;

  assign awvalid_o    = awvalid_q;
  assign awid_o       = TxnId;
  assign awaddr_o     = awaddr_q;
  assign awsize_o     = awsize_q;
  assign awlen_o      = awlen_q;
  assign awburst_o    = awburst_q;
  assign wvalid_o     = wvalid_q;
  assign wdata_o      = wdata_q;
  assign wstrb_o      = wstrb_q;
  assign wlast_o      = wlast_q;
  assign bready_o     = bready_q;

  assign arvalid_o    = arvalid_q;
  assign arid_o       = TxnId;
  assign araddr_o     = araddr_q;
  assign arsize_o     = arsize_q;
  assign arlen_o      = arlen_q;
  assign arburst_o    = arburst_q;
  assign rready_o     = rready_q;

endmodule

// File: doc/scr1_axi_single_master.md
# scr1_axi_single_master

Single-outstanding AXI4 initiator converting a simple core-style memory request/response port into single-beat AXI read and write transactions. Sits between a testbench traffic source, or a core memory port, and any AXI responder such as the AXI memory testbench model. Generates byte strobes, checks responses, and rejects misaligned accesses locally without issuing bus traffic.

## Interface
- W_ID, 4, AXI ID width
- W_ADR, 32, address width
- W_DATA, 32, data width; only 32 is supported
- TXN_ID, 0, constant ID driven on awid/arid and expected on bid/rid
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req  in  1  request valid
- req_ack  out  1  request accepted when req & req_ack at posedge
- req_we  in  1  1 = write, 0 = read
- req_width  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- req_addr  in  W_ADR  byte address
- req_wdata  in  W_DATA  write data, lane-aligned to the address
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  W_DATA  read data exactly as received on rdata (lane-aligned)
- resp_err  out  1  error flag, qualified by resp_valid
- awvalid/awready, awid W_ID, awaddr W_ADR, awsize 3, awlen 8, awburst 2: AXI write-address channel (out except awready)
- wvalid/wready, wdata W_DATA, wstrb W_DATA/8, wlast 1: AXI write-data channel (out except wready)
- bvalid/bready, bid W_ID, bresp 2: AXI write-response channel (in except bready)
- arvalid/arready, arid W_ID, araddr W_ADR, arsize 3, arlen 8, arburst 2: AXI read-address channel (out except arready)
- rvalid/rready, rid W_ID, rdata W_DATA, rlast 1, rresp 2: AXI read-data channel (in except rready)

## Operation
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, ERR.
- req_ack = (state == IDLE). On acceptance, addr, width, we and wdata are registered.
- Misalignment check: width 3, half with addr[0] set, or word with addr[1:0] != 0 -> ERR. No AXI traffic is issued.
- IDLE -> RD_A on a read, -> WR_AW on a write, -> ERR on a misaligned request.
- RD_A: arvalid=1. araddr = registered address, arsize = width, arlen=0, arburst=INCR (2'b01), arid=TXN_ID. On arready, go to RD_D.
- RD_D: rready=1. On rvalid:
  - capture rdata.
  - resp_err = (rresp != 0) | (rid != TXN_ID) | ~rlast.
  - go to IDLE, pulsing resp_valid.
- WR_AW: awvalid and wvalid both rise on entry.
  - Each drops independently after its own handshake; the done flags are registered.
  - wlast=1. wstrb = 4'b0001 << addr[1:0] for byte, 4'b0011 << addr[1:0] for half, 4'hF for word.
  - Go to WR_B when both channels have completed, including the case where both complete in the same cycle.
- WR_B: bready=1. On bvalid: resp_err = (bresp != 0) | (bid != TXN_ID); go to IDLE, pulsing resp_valid.
- ERR: for one cycle, resp_valid=1 and resp_err=1; then go to IDLE.
- AXI payload is held stable while valid is high and ready is low. Valid is never withdrawn before its handshake.
- rvalid/bvalid arriving outside RD_D/WR_B are ignored (ready is low).

## Timing
- Reset values:
  - all valid/ready outputs 0.
  - aw*/ar*/wdata/wstrb 0; wlast 0; awid/arid TXN_ID.
  - resp_valid 0, resp_err 0, resp_rdata 0.
  - state IDLE, so req_ack=1 once reset is released.
- Assertion of rst_n mid-transaction abandons the transfer asynchronously: outputs return to their reset values and no resp_valid is produced.
- Read with zero wait states: accept at edge 0; arvalid high in cycle 1; rready high in cycle 2; rvalid at edge 2; resp_valid in cycle 3. Latency is 3 cycles from acceptance to response.
- Write with zero wait states: awvalid/wvalid high in cycle 1; bready high in cycle 2; resp_valid in cycle 3.
- Misaligned request: resp_valid/resp_err in cycle 1.
- resp_valid is a one-cycle registered pulse. req_ack is high in the same cycle (back-to-back accept is allowed). Throughput is at most one transaction per 3 cycles.
- resp_rdata holds its value until the next read response. It is not updated on writes.

## Test plan
- Word read, addr 0x100, responder returns 0xDEADBEEF with rresp=0 -> araddr=0x100, arsize=2, arlen=0; resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 3 cycles after accept.
- Byte write, addr 0x103, wdata 0xAB000000 -> awsize=0, wstrb=4'b1000, wlast=1; resp_err=0 after bvalid.
- awready held low 4 cycles while wready=1 -> wvalid drops after 1 cycle; awvalid and awaddr stay stable until the handshake; bready is asserted only after both handshakes.
- Half read at 0x101, then word write at 0x102 -> each produces resp_valid=1, resp_err=1 one cycle after accept, with zero AXI valids.
- Read with rresp=2'b10, then write with bid != TXN_ID -> resp_err=1 on both responses; the next request is accepted normally.
- rst_n asserted while in RD_D with rvalid pending -> arvalid/rready=0 immediately, no resp_valid; after reset release req_ack=1 and a fresh read completes correctly.
